// File: rtl/decode_imm_extend_pipe.sv
// decode_imm_extend_pipe: registered immediate-extension stage for the ID/EX
// boundary. Extends an IN_W-bit immediate to OUT_W bits in one of four modes
// (sign, zero, upper-load, branch offset) and holds the result in a pipeline
// register with valid/stall/flush control.
// Optional feature macro: DECODE_EXT_STATS_EN adds the neg_count port and a
// CNT_W-bit saturating counter of loads whose result has its MSB set.
module decode_imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [IN_W-1:0]  instruction,
  input  logic [1:0]       mode,
  output logic             out_valid,
  output logic [OUT_W-1:0] extended_instruction,
  output logic [1:0]       out_mode
`ifdef DECODE_EXT_STATS_EN
  ,
  output logic [CNT_W-1:0] neg_count
`endif
);

  typedef enum logic [1:0] {
    MODE_SIGN   = 2'b00,
    MODE_ZERO   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } mode_e;

  // The branch shift needs two spare bits above the immediate.
  if (OUT_W < IN_W + 2) begin : g_width_check
    $error("decode_imm_extend_pipe: OUT_W must be >= IN_W+2");
  end
  if (CNT_W < 1) begin : g_cnt_check
    $error("decode_imm_extend_pipe: CNT_W must be >= 1");
  end

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext_new;
  logic             load;

  logic             out_valid_d, out_valid_q;
  logic [OUT_W-1:0] ext_d, ext_q;
  logic [1:0]       out_mode_d, out_mode_q;

  // Combinational extension of the incoming immediate.
  always_comb begin
    sext = {{(OUT_W-IN_W){instruction[IN_W-1]}}, instruction};
    unique case (mode_e'(mode))
      MODE_SIGN:   ext_new = sext;
      MODE_ZERO:   ext_new = {{(OUT_W-IN_W){1'b0}}, instruction};
      MODE_UPPER:  ext_new = {instruction, {(OUT_W-IN_W){1'b0}}};
      MODE_BRANCH: ext_new = sext << 2;
      default:     ext_new = '0;
    endcase
  end

  // A real result is captured only when neither flushing nor stalling.
  assign load = !flush && !stall && in_valid;

  // Next-state for the pipeline register: flush > stall > load/bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    ext_d       = ext_q;
    out_mode_d  = out_mode_q;
    if (flush) begin
      out_valid_d = 1'b0;
      ext_d       = '0;
      out_mode_d  = '0;
    end else if (!stall) begin
      out_valid_d = in_valid;
      ext_d       = in_valid ? ext_new : '0;
      out_mode_d  = in_valid ? mode : '0;
    end
  end

  // Pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      ext_q       <= '0;
      out_mode_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ext_q       <= ext_d;
      out_mode_q  <= out_mode_d;
    end
  end

  assign out_valid            = out_valid_q;
  assign extended_instruction = ext_q;
  assign out_mode             = out_mode_q;

`ifdef DECODE_EXT_STATS_EN
  logic [CNT_W-1:0] neg_count_d, neg_count_q;

  // Saturating count of loads producing a negative result.
  always_comb begin
    neg_count_d = neg_count_q;
    if (load && ext_new[OUT_W-1] && (neg_count_q != '1)) begin
      neg_count_d = neg_count_q + CNT_W'(1);
    end
  end

  // Statistics counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_count_q <= '0;
    end else begin
      neg_count_q <= neg_count_d;
    end
  end

  assign neg_count = neg_count_q;
`else
  logic unused_load;
  assign unused_load = load;
`endif

endmodule
